// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Purpose: bundles the ROM port, redirect port and decode-side valid/ready
// stream of the instruction-fetch sequencer.
//
// Signals:
//   fetch_en        permits new fetches when high
//   rom_addr        ROM word address (ADDR_W bits)
//   rom_instr       ROM read data, valid the cycle after an issued address
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     byte target PC of the redirect
//   out_valid       output buffer head valid
//   out_ready       decode accepts the head
//   out_instr       head instruction
//   out_pc          byte PC of the head instruction
//   fetch_err       sticky misaligned-redirect flag
//
// Modports:
//   master  the fetch sequencer itself
//   slave   the surrounding core / ROM / decode side
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              fetch_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              fetch_err;

    modport master (
        input  fetch_en,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output rom_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        output fetch_err
    );

    modport slave (
        output fetch_en,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  rom_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  fetch_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose: instruction-fetch controller for a synchronous instruction ROM with
// a one-cycle registered read. Owns the PC, issues one ROM read per cycle when
// there is room downstream, captures the returned word one cycle later into a
// small output FIFO, and presents a valid/ready stream {out_instr, out_pc} to
// decode. Redirects flush the FIFO and kill the in-flight read; a misaligned
// redirect target parks the sequencer in ERR with a sticky fetch_err.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_sequencer_if.master (ROM port, redirect, output stream,
//          fetch_en, fetch_err)
//
// Parameters:
//   RESET_PC    byte PC loaded at reset
//   FIFO_DEPTH  output buffer entries (power of 2, >= 2)
//   ADDR_W      ROM word-address width
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          ADDR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic              fetch_err_reg, fetch_err_next;
    logic              inflight_reg;
    logic [31:0]       inflight_pc_reg;

    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [31:0]       instr_mem [FIFO_DEPTH];
    logic [31:0]       pc_mem    [FIFO_DEPTH];

    logic              pop, push, issue, misaligned, fifo_valid;
    logic [OCC_W-1:0]  occupancy;

    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid & bus.out_ready;
    assign misaligned = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);

    // Slots that will be taken once this cycle's pop is gone: buffered words
    // plus the read already in flight. Issuing only below FIFO_DEPTH means a
    // returning word always has a slot, so nothing is ever dropped.
    assign occupancy = OCC_W'(count_reg) + OCC_W'(inflight_reg) - OCC_W'(pop);
    assign issue     = (state_reg == ST_RUN) & ~bus.redirect_valid
                     & (occupancy < OCC_W'(FIFO_DEPTH));

    // A word returning in a redirect cycle belongs to the old path.
    assign push = inflight_reg & ~bus.redirect_valid;

    // ROM address is the word index of the PC; upper PC bits are ignored,
    // so fetching past the last word silently wraps to word 0.
    assign bus.rom_addr  = pc_reg[ADDR_W+1:2];
    assign bus.out_valid = fifo_valid;
    assign bus.out_instr = fifo_valid ? instr_mem[rd_ptr_reg] : '0;
    assign bus.out_pc    = fifo_valid ? pc_mem[rd_ptr_reg]    : '0;
    assign bus.fetch_err = fetch_err_reg;

    // ------------------------------------------------------------------
    // Control FSM: next state, next PC, sticky error
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        fetch_err_next = fetch_err_reg;

        if (bus.redirect_valid) begin
            if (misaligned) begin
                state_next     = ST_ERR;
                pc_next        = bus.redirect_pc & ~32'd3;
                fetch_err_next = 1'b1;
            end else begin
                state_next     = bus.fetch_en ? ST_RUN : ST_IDLE;
                pc_next        = bus.redirect_pc;
                fetch_err_next = 1'b0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: if (bus.fetch_en)  state_next = ST_RUN;
                ST_RUN:  if (!bus.fetch_en) state_next = ST_IDLE;
                ST_ERR:  state_next = ST_ERR;   // only a redirect or reset leaves
                default: state_next = ST_IDLE;
            endcase
            if (issue) begin
                pc_next = pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            fetch_err_reg   <= 1'b0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            fetch_err_reg <= fetch_err_next;
            // issue is already low in a redirect cycle, which kills the
            // in-flight tag together with the flush.
            inflight_reg  <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO bookkeeping. A redirect empties it after any same-cycle
    // handshake has been honoured (the consumer already took the head).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (bus.redirect_valid) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset: the outputs are forced to zero while
    // the FIFO is empty, and an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= bus.rom_instr;
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Two sequencer instances with behavioural ROMs: dut_a starts at PC 0 and
// exercises stall, redirect, misaligned redirect and mid-run reset; dut_b
// starts at 0xFF8 to exercise the ROM word-address wrap. Expected PCs are
// queued when the stimulus sets up each stream and popped by a monitor on
// every accepted output word; the instruction is derived from the PC.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;

    fetch_sequencer_if #(.ADDR_W(10)) ifa ();
    fetch_sequencer_if #(.ADDR_W(10)) ifb ();

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .ADDR_W     (10)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ifa)
    );

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0FF8),
        .FIFO_DEPTH (2),
        .ADDR_W     (10)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    function automatic logic [31:0] rom_word(input logic [9:0] w);
        return {6'h2B, w, 6'h15, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ROMs: one-cycle registered read.
    always @(posedge clk) begin
        ifa.rom_instr <= rom_word(ifa.rom_addr);
        ifb.rom_instr <= rom_word(ifb.rom_addr);
    end

    // Scoreboard monitors: one line per accepted word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hDEAD_BEEF;
            $display("a pop pc=0x%08h instr=0x%08h exp_pc=0x%08h", ifa.out_pc, ifa.out_instr, e);
            check("a_sb_pc", ifa.out_pc, e);
            check("a_sb_instr", ifa.out_instr, rom_word(e[11:2]));
        end
        if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 32'hDEAD_BEEF;
            $display("b pop pc=0x%08h instr=0x%08h exp_pc=0x%08h", ifb.out_pc, ifb.out_instr, e);
            check("b_sb_pc", ifb.out_pc, e);
            check("b_sb_instr", ifb.out_instr, rom_word(e[11:2]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int b_addr [5];
        b_addr = '{1022, 1022, 1023, 0, 1};

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        ifa.fetch_en = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0; ifa.out_ready = 1'b1;
        ifb.fetch_en = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0; ifb.out_ready = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc();
        @(negedge clk);
        check("rst_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_instr", ifa.out_instr, 32'd0);
        check("rst_pc", ifa.out_pc, 32'd0);
        check("rst_err", 32'(ifa.fetch_err), 32'd0);
        check("rst_addr", 32'(ifa.rom_addr), 32'd0);
        check("b_rst_addr", 32'(ifb.rom_addr), 32'd1022);

        cyc();
        rst_n_a = 1'b1;
        cyc();
        ifa.fetch_en  = 1'b1;
        ifa.out_ready = 1'b0;

        // ---------------- first-word latency ----------------
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.out_valid !== 1'b1 && n < 20);
        check("a_first_lat", 32'(n), 32'd4);

        // ---------------- stall: head held, issue gated ----------------
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check("a_stall_valid", 32'(ifa.out_valid), 32'd1);
            check("a_stall_pc", ifa.out_pc, 32'h0);
        end
        check("a_stall_addr", 32'(ifa.rom_addr), 32'd2);

        exp_a.push_back(32'h0);
        exp_a.push_back(32'h4);
        cyc(); ifa.out_ready = 1'b1;       // pop 0x0
        cyc();                             // pop 0x4
        cyc(); ifa.out_ready = 1'b0;
        cyc();
        @(negedge clk);
        check("a_hold8_valid", 32'(ifa.out_valid), 32'd1);
        check("a_hold8_pc", ifa.out_pc, 32'h8);

        // ---------------- redirect to 0x100 flushes 0x8/0xC ----------------
        cyc();
        ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h100;
        cyc();
        ifa.redirect_valid = 1'b0; ifa.out_ready = 1'b1;
        exp_a.push_back(32'h100);
        exp_a.push_back(32'h104);
        exp_a.push_back(32'h108);
        @(negedge clk);
        check("a_redir_v1", 32'(ifa.out_valid), 32'd0);
        check("a_redir_addr", 32'(ifa.rom_addr), 32'h40);
        cyc();
        @(negedge clk);
        check("a_redir_v2", 32'(ifa.out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("a_redir_v3", 32'(ifa.out_valid), 32'd1);   // pops 0x100
        cyc();                                              // pops 0x104

        // ---------------- misaligned redirect with simultaneous pop ----------------
        cyc();
        ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h102;
        @(negedge clk);
        check("a_pop_at_redir", 32'(ifa.out_valid), 32'd1); // pops 0x108
        cyc();
        ifa.redirect_valid = 1'b0;
        @(negedge clk);
        check("a_err_addr", 32'(ifa.rom_addr), 32'h40);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                cyc();
                @(negedge clk);
            end
            check("a_err_flag", 32'(ifa.fetch_err), 32'd1);
            check("a_err_valid", 32'(ifa.out_valid), 32'd0);
        end

        // ---------------- aligned redirect leaves ERR ----------------
        cyc();
        ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h200;
        exp_a.push_back(32'h200);
        exp_a.push_back(32'h204);
        cyc();
        ifa.redirect_valid = 1'b0;
        @(negedge clk);
        check("a_err_clear", 32'(ifa.fetch_err), 32'd0);
        check("a_rec_v1", 32'(ifa.out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("a_rec_v2", 32'(ifa.out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("a_rec_v3", 32'(ifa.out_valid), 32'd1);      // pops 0x200
        cyc();                                              // pops 0x204
        cyc();
        ifa.out_ready = 1'b0;
        cyc();
        @(negedge clk);
        check("a_full_pc", ifa.out_pc, 32'h208);

        // ---------------- reset mid-operation ----------------
        #2;
        rst_n_a = 1'b0;
        #1;
        check("a_midrst_valid", 32'(ifa.out_valid), 32'd0);
        check("a_midrst_pc", ifa.out_pc, 32'd0);
        check("a_midrst_instr", ifa.out_instr, 32'd0);
        check("a_midrst_addr", 32'(ifa.rom_addr), 32'd0);
        cyc(); cyc();
        rst_n_a = 1'b1;
        ifa.out_ready = 1'b1;
        exp_a.push_back(32'h0);
        exp_a.push_back(32'h4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.out_valid !== 1'b1 && n < 20);
        check("a_restart_lat", 32'(n), 32'd4);              // pops 0x0
        cyc();                                              // pops 0x4
        cyc();
        ifa.out_ready = 1'b0;
        ifa.fetch_en  = 1'b0;

        // ---------------- dut_b: word-address wrap ----------------
        cyc();
        rst_n_b = 1'b1;
        ifb.fetch_en  = 1'b1;
        ifb.out_ready = 1'b1;
        exp_b.push_back(32'h0000_0FF8);
        exp_b.push_back(32'h0000_0FFC);
        exp_b.push_back(32'h0000_1000);
        exp_b.push_back(32'h0000_1004);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 5) check("b_wrap_addr", 32'(ifb.rom_addr), 32'(b_addr[i]));
            if (i == 2) check("b_pre_valid", 32'(ifb.out_valid), 32'd0);
            if (i >= 3) check("b_stream_valid", 32'(ifb.out_valid), 32'd1);
        end
        cyc();
        ifb.out_ready = 1'b0;
        ifb.fetch_en  = 1'b0;
        @(negedge clk);

        check("a_sb_drain", 32'(exp_a.size()), 32'd0);
        check("b_sb_drain", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
